// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard scoreboard: the per-stage entry
// record, the default register width and a saturating increment.
package hazard_scoreboard_pkg;

  localparam int DEF_REG_W = 6;
  // Entries store addresses at this fixed width so the struct can live in the package.
  localparam int MAX_REG_W = 16;

  typedef struct packed {
    logic                 v;
    logic                 dv;
    logic [MAX_REG_W-1:0] daddr;
    logic                 ww;
  } sb_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    if (val >= max_val) return max_val;
    return val + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_cmp.sv
// Compares one source operand against every scoreboard entry and reports
// the per-entry hit vector plus the index of the youngest matching entry.
module hazard_cmp
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IDX_W = 1
) (
  input  logic                 req_i,
  input  logic [MAX_REG_W-1:0] src_addr_i,
  input  sb_entry_t            entries_i [DEPTH],
  output logic [DEPTH-1:0]     hit_o,
  output logic [IDX_W-1:0]     young_idx_o
);

  always_comb begin
    hit_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit_o[k] = req_i & entries_i[k].v & entries_i[k].dv &
                 (entries_i[k].daddr == src_addr_i);
    end
  end

  // Scan oldest to youngest so the lowest matching index ends up winning.
  always_comb begin
    young_idx_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit_o[k]) young_idx_o = IDX_W'(k);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Data-hazard and stall unit: a shift-register scoreboard of in-flight
// destinations checked against the issuing instruction's sources and W flags.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_W   = DEF_REG_W,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int FWD_EN  = 0,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*REG_W-1:0] src_addr,
  input  logic                     dst_valid,
  input  logic [REG_W-1:0]         dst_addr,
  input  logic                     w_read,
  input  logic                     w_write,
  input  logic                     ex_ready,
  input  logic                     flush,
  output logic                     stall,
  output logic [NUM_SRC-1:0]       fwd_hit,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] OLDEST = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sb_entry_t        sb_q [DEPTH];
  sb_entry_t        sb_d [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [DEPTH-1:0] hit_s   [NUM_SRC];
  logic [IDX_W-1:0] young_s [NUM_SRC];
  logic             reg_stall;
  logic             w_stall;

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      hazard_cmp #(
        .DEPTH(DEPTH),
        .IDX_W(IDX_W)
      ) u_cmp (
        .req_i      (id_valid & src_valid[g]),
        .src_addr_i (MAX_REG_W'(src_addr[g*REG_W +: REG_W])),
        .entries_i  (sb_q),
        .hit_o      (hit_s[g]),
        .young_idx_o(young_s[g])
      );
    end
  endgenerate

  // A hit whose youngest match is the oldest stage can be forwarded; any
  // younger match still has to wait for its producer to move along.
  always_comb begin
    reg_stall = 1'b0;
    fwd_hit   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (|hit_s[i]) begin
        if ((FWD_EN != 0) && (young_s[i] == OLDEST)) fwd_hit[i] = 1'b1;
        else                                         reg_stall  = 1'b1;
      end
    end
  end

  always_comb begin
    w_stall = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sb_q[k].v && sb_q[k].ww) w_stall = 1'b1;
    end
    w_stall = w_stall & id_valid & w_read;
  end

  assign stall     = reg_stall | w_stall;
  assign stall_cnt = cnt_q;

  always_comb begin
    sb_d = sb_q;
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) sb_d[k].v = 1'b0;
    end else if (ex_ready) begin
      for (int k = DEPTH - 1; k >= 1; k--) sb_d[k] = sb_q[k-1];
      if (id_valid && !stall) begin
        sb_d[0] = '{v: 1'b1, dv: dst_valid, daddr: MAX_REG_W'(dst_addr), ww: w_write};
      end else begin
        sb_d[0] = '0;
      end
    end
  end

  // Stalls are counted even while the scoreboard is frozen or flushing.
  always_comb begin
    cnt_d = cnt_q;
    if (stall) cnt_d = CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_MAX)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) sb_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Drives two scoreboards (stall-only and forwarding) with one input stream
// and checks both against an in-bench model of in-flight instructions.
module tb_hazard_scoreboard;

  localparam int REG_W   = 6;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 2;
  localparam int CW0     = 4;
  localparam int CW1     = 16;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     id_valid;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC*REG_W-1:0] src_addr;
  logic                     dst_valid;
  logic [REG_W-1:0]         dst_addr;
  logic                     w_read;
  logic                     w_write;
  logic                     ex_ready;
  logic                     flush;

  logic               stall0, stall1;
  logic [NUM_SRC-1:0] fwd0, fwd1;
  logic [CW0-1:0]     cnt0;
  logic [CW1-1:0]     cnt1;

  int checks = 0;
  int errors = 0;

  // Model of what is in flight, one lane per DUT: index 0 youngest.
  bit mv   [2][DEPTH];
  bit mdv  [2][DEPTH];
  bit mww  [2][DEPTH];
  int maddr[2][DEPTH];
  int mcnt [2];
  bit modelOk = 1'b0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .FWD_EN(0), .CNT_W(CW0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .src_valid(src_valid),
    .src_addr(src_addr), .dst_valid(dst_valid), .dst_addr(dst_addr),
    .w_read(w_read), .w_write(w_write), .ex_ready(ex_ready), .flush(flush),
    .stall(stall0), .fwd_hit(fwd0), .stall_cnt(cnt0)
  );

  hazard_scoreboard #(
    .REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .FWD_EN(1), .CNT_W(CW1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .src_valid(src_valid),
    .src_addr(src_addr), .dst_valid(dst_valid), .dst_addr(dst_addr),
    .w_read(w_read), .w_write(w_write), .ex_ready(ex_ready), .flush(flush),
    .stall(stall1), .fwd_hit(fwd1), .stall_cnt(cnt1)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit idv, input bit [1:0] sv, input int s0, input int s1,
                               input bit dv, input int da, input bit wr, input bit ww,
                               input bit er, input bit fl);
    id_valid  = idv;
    src_valid = sv;
    src_addr  = {REG_W'(s1), REG_W'(s0)};
    dst_valid = dv;
    dst_addr  = REG_W'(da);
    w_read    = wr;
    w_write   = ww;
    ex_ready  = er;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The youngest in-flight writer of a source decides; only a match in the
  // oldest stage may be forwarded, and only by the forwarding DUT.
  function automatic void calcExpected(input int d, output bit st, output bit [1:0] fw);
    int young;
    st = 1'b0;
    fw = '0;
    if (!id_valid) return;
    for (int i = 0; i < NUM_SRC; i++) begin
      young = -1;
      if (src_valid[i]) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (young < 0 && mv[d][k] && mdv[d][k] && maddr[d][k] == int'(src_addr[i*REG_W +: REG_W]))
            young = k;
        end
      end
      if (young >= 0) begin
        if (d == 1 && young == DEPTH - 1) fw[i] = 1'b1;
        else                              st    = 1'b1;
      end
    end
    if (w_read) begin
      for (int k = 0; k < DEPTH; k++) if (mv[d][k] && mww[d][k]) st = 1'b1;
    end
  endfunction

  initial forever begin
    bit st;
    bit [1:0] fw;
    int maxc;
    @(posedge clk);
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < DEPTH; k++) mv[d][k] = 1'b0;
        mcnt[d] = 0;
      end
      modelOk = 1'b1;
    end else if (modelOk) begin
      for (int d = 0; d < 2; d++) begin
        calcExpected(d, st, fw);
        maxc = (d == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
        if (st && mcnt[d] < maxc) mcnt[d]++;
        if (flush) begin
          for (int k = 0; k < DEPTH; k++) mv[d][k] = 1'b0;
        end else if (ex_ready) begin
          for (int k = DEPTH - 1; k > 0; k--) begin
            mv[d][k] = mv[d][k-1]; mdv[d][k] = mdv[d][k-1];
            mww[d][k] = mww[d][k-1]; maddr[d][k] = maddr[d][k-1];
          end
          mv[d][0]    = id_valid && !st;
          mdv[d][0]   = dst_valid;
          mww[d][0]   = w_write;
          maddr[d][0] = int'(dst_addr);
        end
      end
    end
  end

  initial forever begin
    bit st;
    bit [1:0] fw;
    @(negedge clk);
    if (modelOk) begin
      calcExpected(0, st, fw);
      checkOutput("model stall dut0", int'(stall0), int'(st));
      checkOutput("model fwd dut0", int'(fwd0), int'(fw));
      checkOutput("model cnt dut0", int'(cnt0), mcnt[0]);
      calcExpected(1, st, fw);
      checkOutput("model stall dut1", int'(stall1), int'(st));
      checkOutput("model fwd dut1", int'(fwd1), int'(fw));
      checkOutput("model cnt dut1", int'(cnt1), mcnt[1]);
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset stall0", int'(stall0), 0);
    checkOutput("reset fwd1", int'(fwd1), 0);
    checkOutput("reset cnt0", int'(cnt0), 0);

    // Back-to-back RAW on r5
    tick();
    applyStimulus(1, 2'b00, 0, 0, 1, 5, 0, 0, 1, 0);
    tick();
    applyStimulus(1, 2'b01, 5, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("raw c1 stall0", int'(stall0), 1);
    checkOutput("raw c1 stall1", int'(stall1), 1);
    tick(); @(negedge clk);
    checkOutput("raw c2 stall0", int'(stall0), 1);
    checkOutput("raw c2 stall1", int'(stall1), 0);
    checkOutput("raw c2 fwd1", int'(fwd1), 1);
    tick(); @(negedge clk);
    checkOutput("raw c3 stall0", int'(stall0), 0);
    checkOutput("raw cnt0", int'(cnt0), 2);
    checkOutput("raw cnt1", int'(cnt1), 1);

    // W hazard
    tick();
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) tick();
    applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    applyStimulus(1, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0);
    @(negedge clk);
    checkOutput("w c1 stall0", int'(stall0), 1);
    checkOutput("w c1 stall1", int'(stall1), 1);
    tick(); @(negedge clk);
    checkOutput("w c2 stall0", int'(stall0), 1);
    checkOutput("w c2 stall1", int'(stall1), 1);
    tick(); @(negedge clk);
    checkOutput("w c3 stall0", int'(stall0), 0);
    checkOutput("w c3 stall1", int'(stall1), 0);

    // Freeze with r7 producer, then flush
    tick();
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) tick();
    applyStimulus(1, 2'b00, 0, 0, 1, 7, 0, 0, 1, 0);
    tick();
    applyStimulus(1, 2'b10, 0, 7, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("freeze stall0", int'(stall0), 1);
      checkOutput("freeze stall1", int'(stall1), 1);
      tick();
    end
    flush = 1'b1;
    @(negedge clk);
    checkOutput("freeze cnt0", int'(cnt0), 7);
    checkOutput("freeze cnt1", int'(cnt1), 6);
    tick();
    flush = 1'b0;
    ex_ready = 1'b1;
    @(negedge clk);
    checkOutput("flush stall0", int'(stall0), 0);
    checkOutput("flush stall1", int'(stall1), 0);
    checkOutput("flush cnt0", int'(cnt0), 8);

    // Saturation on the 4-bit counter
    tick();
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) tick();
    applyStimulus(1, 2'b00, 0, 0, 1, 7, 0, 0, 1, 0);
    tick();
    applyStimulus(1, 2'b10, 0, 7, 0, 0, 0, 0, 0, 0);
    repeat (20) tick();
    @(negedge clk);
    checkOutput("sat cnt0", int'(cnt0), 15);
    checkOutput("sat cnt1", int'(cnt1), 27);
    tick();
    rst_n = 1'b0;
    flush = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("rst cnt0", int'(cnt0), 0);
    checkOutput("rst cnt1", int'(cnt1), 0);
    checkOutput("rst stall0", int'(stall0), 0);
    checkOutput("rst stall1", int'(stall1), 0);
    tick();
    rst_n = 1'b1;
    flush = 1'b0;

    // Randomised traffic on a small register set to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst_n = ($urandom_range(0, 199) != 0);
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 1) != 0, $urandom_range(0, 7),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
    end
    tick();
    rst_n = 1'b1;
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
